// File: rtl/mem_bus_router.sv
// Single-master address router: decodes a core request onto one of three slaves,
// waits for that slave's ready (bounded by a timeout), and returns data or an error.
module mem_bus_router #(
  parameter logic [31:0] S0_BASE     = 32'h0000_0000,
  parameter logic [31:0] S0_MASK     = 32'hFF00_0000,
  parameter logic [31:0] S1_BASE     = 32'h0300_0000,
  parameter logic [31:0] S1_MASK     = 32'hFF00_0000,
  parameter logic [31:0] S2_BASE     = 32'h1000_0000,
  parameter logic [31:0] S2_MASK     = 32'hF000_0000,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_valid_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  input  logic [3:0]  core_wstrb_i,
  output logic [31:0] core_rdata_o,
  output logic        core_ready_o,
  output logic [2:0]  slv_valid_o,
  output logic [31:0] slv_addr_o,
  output logic [31:0] slv_wdata_o,
  output logic [3:0]  slv_wstrb_o,
  input  logic [95:0] slv_rdata_i,
  input  logic [2:0]  slv_ready_i,
  output logic        bus_err_o,
  output logic [31:0] err_addr_o
);

  // state  | meaning
  // IDLE   | waiting for a core request
  // ACCESS | request presented to the selected slave
  // RESP   | one-cycle completion with slave read data
  // ERR    | one-cycle completion with error (decode miss or timeout)
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [2:0]  match;
  logic [2:0]  sel_dec;
  logic [31:0] sel_rdata;
  logic        rdy_sel;
  logic        timeout_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Lowest matching index wins when windows overlap.
  always_comb begin
    match[0] = ((core_addr_i & S0_MASK) == S0_BASE);
    match[1] = ((core_addr_i & S1_MASK) == S1_BASE);
    match[2] = ((core_addr_i & S2_MASK) == S2_BASE);
    if (match[0])      sel_dec = 3'b001;
    else if (match[1]) sel_dec = 3'b010;
    else if (match[2]) sel_dec = 3'b100;
    else               sel_dec = 3'b000;

    if (sel_q[0])      sel_rdata = slv_rdata_i[31:0];
    else if (sel_q[1]) sel_rdata = slv_rdata_i[63:32];
    else               sel_rdata = slv_rdata_i[95:64];

    rdy_sel     = |(slv_ready_i & sel_q);
    timeout_hit = (TIMEOUT_CYC != 16'd0) && (cnt_q == TIMEOUT_CYC - 16'd1);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (core_valid_i) begin
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          wstrb_d = core_wstrb_i;
          sel_d   = sel_dec;
          cnt_d   = '0;
          if (|sel_dec) begin
            state_d = ACCESS;
          end else begin
            state_d    = ERR;
            err_addr_d = core_addr_i;
          end
        end
      end
      ACCESS: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (rdy_sel) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d    = ERR;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_ready_o = 1'b0;
    core_rdata_o = '0;
    bus_err_o    = 1'b0;
    slv_valid_o  = '0;
    case (state_q)
      ACCESS: slv_valid_o = sel_q;
      RESP: begin
        core_ready_o = 1'b1;
        core_rdata_o = rdata_q;
      end
      ERR: begin
        core_ready_o = 1'b1;
        core_rdata_o = ERR_RDATA;
        bus_err_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;
  assign slv_wstrb_o = wstrb_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: driver pushes expected completions from a
// transaction-level model, a monitor pops and compares whenever the core sees ready.
module tb_mem_bus_router;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_valid = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [3:0]  core_wstrb = '0;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic [2:0]  slv_valid;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;
  logic [95:0] slv_rdata = '0;
  logic [2:0]  slv_ready = '0;
  logic        bus_err;
  logic [31:0] err_addr;

  mem_bus_router #(.TIMEOUT_CYC(16'd8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .core_valid_i(core_valid), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_wstrb_i(core_wstrb),
    .core_rdata_o(core_rdata), .core_ready_o(core_ready),
    .slv_valid_o(slv_valid), .slv_addr_o(slv_addr),
    .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
    .slv_rdata_i(slv_rdata), .slv_ready_i(slv_ready),
    .bus_err_o(bus_err), .err_addr_o(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] err_addr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int plan_d = 0;
  logic [31:0] plan_rd = '0;
  logic [31:0] last_err = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Address map as plain arithmetic; first matching window wins.
  function automatic logic [2:0] decode(input logic [31:0] a);
    if ((a & 32'hFF00_0000) == 32'h0000_0000) return 3'b001;
    if ((a & 32'hFF00_0000) == 32'h0300_0000) return 3'b010;
    if ((a & 32'hF000_0000) == 32'h1000_0000) return 3'b100;
    return 3'b000;
  endfunction

  // Slave side: selected slave raises ready on the plan_d-th access cycle
  // (0 = never); unselected ready bits toggle randomly as noise.
  initial begin
    int acnt;
    acnt = 0;
    forever begin
      @(negedge clk);
      slv_rdata = {$urandom, $urandom, $urandom};
      if (slv_valid == 3'b000) begin
        acnt = 0;
        slv_ready = 3'($urandom);
      end else begin
        acnt++;
        slv_ready = 3'($urandom) & ~slv_valid;
        if (acnt == plan_d) slv_ready = slv_ready | slv_valid;
        for (int i = 0; i < 3; i++)
          if (slv_valid[i]) slv_rdata[32*i +: 32] = plan_rd;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 expected no pending request");
          end else begin
            e = sb.pop_front();
            chk("rdata", core_rdata, e.rdata);
            chk("bus_err", 32'(bus_err), 32'(e.err));
            chk("err_addr", err_addr, e.err_addr);
            chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            chk("slv_valid_in_resp", 32'(slv_valid), 32'd0);
          end
        end else begin
          chk("idle_rdata", core_rdata, 32'd0);
          chk("idle_bus_err", 32'(bus_err), 32'd0);
        end
        if (slv_valid != 3'b000 && sb.size() != 0) begin
          e = sb[0];
          chk("slv_valid", 32'(slv_valid), 32'(e.sel));
          chk("slv_addr", slv_addr, e.addr);
          chk("slv_wdata", slv_wdata, e.wdata);
          chk("slv_wstrb", 32'(slv_wstrb), 32'(e.wstrb));
        end
      end
    end
  end

  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int d, input logic [31:0] rd);
    exp_t e;
    bit   seen;
    @(negedge clk);
    e.sel   = decode(a);
    e.addr  = a;
    e.wdata = wd;
    e.wstrb = ws;
    if (e.sel == 3'b000) begin
      e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.cyc = cyc + 1;
    end else if (d == 0 || d > TO) begin
      e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.cyc = cyc + 1 + TO;
    end else begin
      e.err = 1'b0; e.rdata = rd; e.cyc = cyc + 1 + d;
    end
    if (e.err) last_err = a;
    e.err_addr = last_err;
    plan_d  = d;
    plan_rd = rd;
    sb.push_back(e);
    core_valid = 1'b1;
    core_addr  = a;
    core_wdata = wd;
    core_wstrb = ws;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (core_ready) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_timeout: got no core_ready expected one for addr %h", a);
      sb.delete();
    end
    core_valid = 1'b0;
    core_addr  = $urandom;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(core_ready), 32'd0);
    chk("reset_slv_valid", 32'(slv_valid), 32'd0);
    chk("reset_err_addr", err_addr, 32'd0);
    rst_n = 1'b1;

    do_txn(32'h0300_0010, 32'h0, 4'b0000, 3, 32'h1234_5678);
    do_txn(32'h0000_0040, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0BAD_F00D);
    do_txn(32'h2000_0000, 32'h0, 4'b0000, 1, 32'h1111_1111);
    do_txn(32'h1234_0000, 32'h0, 4'b0000, 0, 32'h2222_2222);
    do_txn(32'h1000_0100, 32'h0, 4'b0000, 8, 32'h3333_3333);
    do_txn(32'h1000_0200, 32'h0, 4'b0000, 9, 32'h4444_4444);
    do_txn(32'h0300_0000, 32'h0, 4'b0000, 2, 32'h5555_5555);

    for (int n = 0; n < 120; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[31:24] = 8'h00;
        1: a[31:24] = 8'h03;
        2: a[31:28] = 4'h1;
        default: ;
      endcase
      do_txn(a, $urandom, 4'($urandom), $urandom_range(0, 10), $urandom);
    end

    // Reset in the middle of an access: abort silently, outputs zero at once.
    @(negedge clk);
    plan_d = 0;
    core_valid = 1'b1;
    core_addr  = 32'h0300_0020;
    core_wdata = 32'hFFFF_0000;
    core_wstrb = 4'b1111;
    @(negedge clk);
    core_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_access", 32'(slv_valid), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_slv_valid", 32'(slv_valid), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_slv_addr", slv_addr, 32'd0);
    chk("rst_slv_wdata", slv_wdata, 32'd0);
    chk("rst_slv_wstrb", 32'(slv_wstrb), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    last_err = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_ready", 32'(core_ready), 32'd0);
    end
    do_txn(32'h1000_0004, 32'h0, 4'b0000, 2, 32'hCAFE_0004);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
